// File: rtl/prime_pkg.sv
// Shared types and defaults for the sequential prime generator.
package prime_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TEST,
    DIV,
    EMIT,
    ADV,
    DONE
  } state_t;

  localparam int PRIME_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/seq_rem.sv
// Restoring remainder unit: a mod b, one dividend bit per cycle.
// rdy pulses for one cycle WIDTH+1 cycles after go; rem stays valid until the next go.
module seq_rem
  import prime_pkg::*;
#(
  parameter int WIDTH = PRIME_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             rdy,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             rdy_q, rdy_d;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    dvd_d = dvd_q;
    dsr_d = dsr_q;
    r_d   = r_q;
    cnt_d = cnt_q;
    run_d = run_q;
    rdy_d = 1'b0;
    trial = {r_q, dvd_q[WIDTH-1]};
    diff  = trial - {1'b0, dsr_q};
    if (go) begin
      dvd_d = a;
      dsr_d = b;
      r_d   = '0;
      cnt_d = CW'(WIDTH);
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q != '0) begin
        // Partial remainder is always < divisor, so the difference fits back in WIDTH bits.
        r_d   = (trial >= {1'b0, dsr_q}) ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q - CW'(1);
      end else begin
        rdy_d = 1'b1;
        run_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd_q <= '0;
      dsr_q <= '0;
      r_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      dvd_q <= dvd_d;
      dsr_q <= dsr_d;
      r_q   <= r_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      rdy_q <= rdy_d;
    end
  end

  assign rdy = rdy_q;
  assign rem = r_q;

endmodule

// File: rtl/prime_gen.sv
// Emits ascending primes in [2, max] on a valid/ready stream, testing each
// candidate by trial division on a shared sequential remainder unit.
module prime_gen
  import prime_pkg::*;
#(
  parameter int WIDTH = PRIME_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] max,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] prime,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] prime_q, prime_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             rem_go;
  logic             rem_rdy;
  logic [WIDTH-1:0] rem_val;
  logic [2*WIDTH-1:0] div_sq;

  seq_rem #(.WIDTH(WIDTH)) u_rem (
    .clk (clk),
    .rst (rst),
    .go  (rem_go),
    .a   (cand_q),
    .b   (div_q),
    .rdy (rem_rdy),
    .rem (rem_val)
  );

  always_comb begin
    state_d     = state_q;
    limit_d     = limit_q;
    cand_d      = cand_q;
    div_d       = div_q;
    prime_d     = prime_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = done_q;
    rem_go      = 1'b0;
    div_sq      = {{WIDTH{1'b0}}, div_q} * {{WIDTH{1'b0}}, div_q};

    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
        if (start) begin
          limit_d = max;
          cand_d  = WIDTH'(2);
          div_d   = WIDTH'(2);
          done_d  = 1'b0;
          busy_d  = (max >= WIDTH'(2));
          state_d = (max >= WIDTH'(2)) ? TEST : DONE;
        end
      end
      TEST: begin
        if (div_sq > {{WIDTH{1'b0}}, cand_q}) begin
          out_valid_d = 1'b1;
          prime_d     = cand_q;
          state_d     = EMIT;
        end else begin
          rem_go  = 1'b1;
          state_d = DIV;
        end
      end
      DIV: begin
        if (rem_rdy) begin
          if (rem_val == '0) begin
            state_d = ADV;
          end else begin
            div_d   = div_q + WIDTH'(1);
            state_d = TEST;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ADV;
        end
      end
      ADV: begin
        // Stop at the limit, and also at all-ones so the candidate never wraps.
        if ((cand_q == limit_q) || (cand_q == '1)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          cand_d  = cand_q + WIDTH'(1);
          div_d   = WIDTH'(2);
          state_d = TEST;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: only control/datapath flops exist here (no memories), so all of them take the async reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      limit_q     <= '0;
      cand_q      <= WIDTH'(2);
      div_q       <= WIDTH'(2);
      prime_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      limit_q     <= limit_d;
      cand_q      <= cand_d;
      div_q       <= div_d;
      prime_q     <= prime_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign prime     = prime_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_prime_gen.sv
// Directed bench for prime_gen at WIDTH=8: vector table of full runs plus
// hand-written latency, back-pressure, ignored-start and mid-run reset sequences.
module tb_prime_gen;

  localparam int W = 8;

  typedef struct {
    int max_v;
    int n_primes;
    int last_prime;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] max;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] prime;
  logic         busy;
  logic         done;

  int n_cmp  = 0;
  int n_fail = 0;

  prime_gen #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .max       (max),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prime     (prime),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_prime_m(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++)
      if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int next_prime_m(input int p);
    int n = p + 1;
    while (!is_prime_m(n)) n++;
    return n;
  endfunction

  // Leaves the bench at the negedge right after the start edge.
  task automatic do_start(input int m);
    @(negedge clk);
    max   = W'(m);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Consumes the stream with out_ready high until done, checking each prime.
  task automatic collect(input int first_exp, output int count, output int last);
    int  exp_p = first_exp;
    bit  fin   = 1'b0;
    count = 0;
    last  = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 20000 && !fin; c++) begin
      if (done) fin = 1'b1;
      else begin
        if (out_valid) begin
          check("stream_prime", prime, exp_p);
          last  = prime;
          exp_p = next_prime_m(exp_p);
          count++;
        end
        @(negedge clk);
      end
    end
    check("stream_finished", fin, 1);
  endtask

  task automatic run_stream(input vec_t v);
    int count, last;
    out_ready = 1'b1;
    do_start(v.max_v);
    check("done_low_after_start", done, 0);
    if (v.n_primes == 0) begin
      @(negedge clk);
      check("done_two_edges", done, 1);
      check("no_valid_small_max", out_valid, 0);
    end
    collect(2, count, last);
    check("prime_count", count, v.n_primes);
    if (v.n_primes > 0) check("last_prime", last, v.last_prime);
    check("done_end", done, 1);
    check("busy_end", busy, 0);
    check("valid_end", out_valid, 0);
  endtask

  task automatic wait_valid(input int budget);
    bit seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("valid_within_budget", seen, 1);
  endtask

  initial begin
    vec_t vecs[8];
    vec_t v5;
    int   count, last;
    bit   seen7;

    vecs[0] = '{10, 4, 7};
    vecs[1] = '{2, 1, 2};
    vecs[2] = '{3, 2, 3};
    vecs[3] = '{13, 6, 13};
    vecs[4] = '{20, 8, 19};
    vecs[5] = '{1, 0, 0};
    vecs[6] = '{0, 0, 0};
    vecs[7] = '{255, 54, 251};
    v5      = '{5, 3, 5};

    rst = 1'b0; start = 1'b0; max = '0; out_ready = 1'b0;
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_prime", prime, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) run_stream(vecs[i]);

    // Latency and back-pressure with max=10.
    out_ready = 1'b0;
    do_start(10);
    check("lat_valid_k", out_valid, 0);
    check("lat_busy_k", busy, 1);
    @(negedge clk);
    check("lat_valid_k1", out_valid, 1);
    check("lat_prime_2", prime, 2);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hs_valid_h", out_valid, 0);
    @(negedge clk);
    check("hs_valid_h1", out_valid, 0);
    @(negedge clk);
    check("hs_valid_h2", out_valid, 1);
    check("hs_prime_3", prime, 3);
    for (int i = 0; i < 5; i++) begin
      out_ready = (i == 2);
      out_ready = 1'b0;
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_prime_3", prime, 3);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    wait_valid(200);
    check("after_hold_prime_5", prime, 5);

    // start during EMIT of 5 must be ignored; the limit stays 10.
    max   = W'(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_valid", out_valid, 1);
    check("ign_prime_5", prime, 5);
    check("ign_busy", busy, 1);
    collect(5, count, last);
    check("ign_count", count, 2);
    check("ign_last", last, 7);
    check("ign_done", done, 1);
    run_stream(v5);

    // Reset while dividing candidate 9.
    out_ready = 1'b1;
    do_start(10);
    seen7 = 1'b0;
    for (int c = 0; c < 2000 && !seen7; c++) begin
      @(negedge clk);
      if (out_valid && prime == W'(7)) seen7 = 1'b1;
    end
    check("saw_prime_7", seen7, 1);
    repeat (16) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_prime", prime, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    run_stream(v5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/prime_gen.md
Name: prime_gen

Overview:
Sequential prime-number generator: the producing end of the count-and-test path. The existing counter/is_prime pair checks one value per cycle, combinationally. This block instead emits the ascending primes in [2, max] one at a time on a valid/ready stream. It tests each candidate by iterative trial division on a shared sequential remainder unit, and is intended to drive checkers and consumers that sit downstream of the counter.

Parameters:
WIDTH, 32, bit width of max, candidate, divisor and emitted prime

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE
max  in  WIDTH  inclusive upper limit, sampled on the start cycle
out_valid  out  1  prime holds a valid prime
out_ready  in  1  consumer accepts prime when high together with out_valid
prime  out  WIDTH  current prime
busy  out  1  high from accepted start until DONE
done  out  1  run complete; held until the next accepted start or reset

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous and active-low.
- Reset values (rst low, immediate): state IDLE, out_valid 0, prime 0, busy 0, done 0, candidate 2, divisor 2, divider idle.
- Reset mid-run aborts any in-flight division and any pending output. No output survives.
- FSM states: IDLE, TEST, DIV, EMIT, ADV, DONE.
- IDLE/DONE + start:
  - latch limit = max; candidate = 2; divisor = 2; done = 0; busy = 1.
  - next state TEST if max >= 2, else DONE with done = 1 on the next edge.
- start in TEST/DIV/EMIT/ADV is ignored.
- TEST (1 cycle):
  - if divisor*divisor > candidate (2*WIDTH-bit product, no overflow), then candidate is prime: EMIT, out_valid = 1, prime = candidate.
  - else launch seq_rem(candidate, divisor) and go to DIV.
- DIV: wait for the seq_rem done pulse (WIDTH+1 cycles after launch).
  - rem == 0: composite, go to ADV.
  - rem != 0: divisor += 1, go to TEST.
- EMIT:
  - out_valid and prime stay stable until out_ready is high.
  - the handshake edge clears out_valid, then go to ADV.
  - out_ready while out_valid is low has no effect.
- ADV (1 cycle):
  - if candidate == limit, or candidate == all-ones (no wrap), go to DONE: done = 1, busy = 0.
  - else candidate += 1, divisor = 2, go to TEST.
- Latency: start sampled at edge k gives out_valid = 1 with prime = 2 after edge k+1. prime = 3 follows an out_ready handshake by 3 edges (ADV, TEST, EMIT).
- Ordering: primes are strictly ascending with no duplicates and none skipped.
- Value bounds: every emitted prime is <= limit. The limit is unaffected by changes to max mid-run.
- Simultaneous events: start coinciding with DONE restarts the run; done drops on that edge.

Decomposition:
- Package prime_pkg:
  - state_t enum {IDLE, TEST, DIV, EMIT, ADV, DONE}
  - PRIME_WIDTH_DEFAULT = 32
- Sub-module seq_rem #(WIDTH), restoring remainder, one bit per cycle:
  - ports clk, rst, go, a, b, rdy, rem
  - rdy pulses once, WIDTH+1 cycles after go
  - b is never 0 (guaranteed by the caller)

Test Plan:
- max=10, out_ready tied 1 -> stream 2,3,5,7, then done=1 and busy=0; exactly 4 handshakes.
- max=10, out_ready low 5 cycles while prime=3 -> out_valid and prime=3 held stable throughout; next value 5 only after out_ready rises.
- max=1 (also max=0) -> no out_valid; done=1 two edges after start.
- WIDTH=8, max=255 -> 54 primes, last 251; done asserted with no wrap past 255.
- rst low during DIV for candidate 9 -> all outputs zero immediately; after release a new start with max=5 gives 2,3,5.
- start pulsed while busy (during EMIT of 5) -> ignored; sequence and limit unchanged; start after done restarts from 2.
